// File: rtl/freq_meter_if.sv
// Bus between freq_meter and its user: the measured input plus the per-window result.
// The master drives sig_in and observes the result; the meter is the slave.
interface freq_meter_if #(
    parameter int CNT_W = 16
);
    logic             sig_in;
    logic [CNT_W-1:0] count_out;
    logic             valid;
    logic             overflow;

    modport master (
        output sig_in,
        input  count_out,
        input  valid,
        input  overflow
    );

    modport slave (
        input  sig_in,
        output count_out,
        output valid,
        output overflow
    );
endinterface

// File: rtl/freq_meter.sv
// Gated frequency meter: counts synchronized rising edges of sig_in over GATE_CYCLES clocks.
// Define FREQ_METER_SATURATE_EN to saturate the edge count at its maximum instead of wrapping.
module freq_meter #(
    parameter int unsigned GATE_CYCLES = 50_000_000,
    parameter int          CNT_W       = 16
) (
    input  logic         clk_50mhz,
    input  logic         rst,
    freq_meter_if.slave  bus
);

    localparam logic [31:0]      GATE_LAST = 32'(GATE_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             hist_q, hist_d;
    logic             rise_q, rise_d;
    logic [31:0]      gate_q, gate_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_flag_q, ovf_flag_d;
    logic [CNT_W-1:0] count_out_q, count_out_d;
    logic             valid_q, valid_d;
    logic             overflow_q, overflow_d;

    logic             terminal;
    logic             cnt_at_max;
    logic             wrap_hit;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] cnt_sum;

    // Detection is registered so an edge lands three cycles after it is first sampled.
    always_comb begin
        sync1_d = bus.sig_in;
        sync2_d = sync1_q;
        hist_d  = sync2_q;
        rise_d  = sync2_q & ~hist_q;
    end

    always_comb begin
        terminal   = (gate_q == GATE_LAST);
        gate_d     = terminal ? 32'd0 : gate_q + 32'd1;
        cnt_at_max = (cnt_q == CNT_MAX);
        wrap_hit   = rise_q & cnt_at_max;
`ifdef FREQ_METER_SATURATE_EN
        cnt_inc    = cnt_at_max ? cnt_q : cnt_q + 1'b1;
`else
        cnt_inc    = cnt_q + 1'b1;
`endif
        cnt_sum    = rise_q ? cnt_inc : cnt_q;
    end

    // An edge detected on the terminal cycle belongs to the closing window, never the next one.
    always_comb begin
        count_out_d = count_out_q;
        overflow_d  = overflow_q;
        cnt_d       = cnt_sum;
        ovf_flag_d  = ovf_flag_q | wrap_hit;
        valid_d     = 1'b0;
        if (terminal) begin
            count_out_d = cnt_sum;
            overflow_d  = ovf_flag_q | wrap_hit;
            cnt_d       = '0;
            ovf_flag_d  = 1'b0;
            valid_d     = 1'b1;
        end
    end

    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            hist_q      <= 1'b0;
            rise_q      <= 1'b0;
            gate_q      <= 32'd0;
            cnt_q       <= '0;
            ovf_flag_q  <= 1'b0;
            count_out_q <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            hist_q      <= hist_d;
            rise_q      <= rise_d;
            gate_q      <= gate_d;
            cnt_q       <= cnt_d;
            ovf_flag_q  <= ovf_flag_d;
            count_out_q <= count_out_d;
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.count_out = count_out_q;
    assign bus.valid     = valid_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_freq_meter.sv
// Directed self-checking bench for freq_meter with GATE_CYCLES=100 and CNT_W=4.
// k counts clock edges since reset release; a window closes after every edge where k is a multiple of 100.
module tb_freq_meter;

    localparam int GATE = 100;
    localparam int W    = 4;
`ifdef FREQ_METER_SATURATE_EN
    localparam logic [W-1:0] OVF_CNT = 4'd15;
`else
    localparam logic [W-1:0] OVF_CNT = 4'd4;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   k = 0;
    int   passed = 0;
    int   total = 0;

    freq_meter_if #(.CNT_W(W)) bus();

    freq_meter #(.GATE_CYCLES(GATE), .CNT_W(W)) dut (
        .clk_50mhz (clk),
        .rst       (rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        k++;
        #1;
    endtask

    task automatic wait_to(input int t);
        while (k < t) tick();
    endtask

    task automatic pulses(input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            bus.sig_in = 1'b1;
            repeat (hi) tick();
            bus.sig_in = 1'b0;
            repeat (lo) tick();
        end
    endtask

    task automatic release_reset();
        rst = 1'b0;
        k   = 0;
    endtask

    // Runs to the next window boundary, noting any valid seen before it, and samples the result there.
    task automatic run_window(output bit early, output logic vld,
                              output logic [W-1:0] cnt, output logic ovf);
        int target;
        target = (k / GATE + 1) * GATE;
        early  = 1'b0;
        while (k < target) begin
            tick();
            if (k < target && bus.valid !== 1'b0) early = 1'b1;
        end
        vld = bus.valid;
        cnt = bus.count_out;
        ovf = bus.overflow;
    endtask

    task automatic test_reset();
        bus.sig_in = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        total++; if (bus.count_out !== 4'd0) $display("[TB] FAIL reset_count got %0d want 0", bus.count_out); else passed++;
        total++; if (bus.valid !== 1'b0) $display("[TB] FAIL reset_valid got %b want 0", bus.valid); else passed++;
        total++; if (bus.overflow !== 1'b0) $display("[TB] FAIL reset_overflow got %b want 0", bus.overflow); else passed++;
        release_reset();
    endtask

    task automatic test_idle_window();
        bit early; logic vld; logic [W-1:0] cnt; logic ovf;
        run_window(early, vld, cnt, ovf);
        total++; if (early !== 1'b0) $display("[TB] FAIL idle_early_valid got %b want 0", early); else passed++;
        total++; if (vld !== 1'b1) $display("[TB] FAIL idle_valid_at_100 got %b want 1", vld); else passed++;
        total++; if (cnt !== 4'd0) $display("[TB] FAIL idle_count got %0d want 0", cnt); else passed++;
        total++; if (ovf !== 1'b0) $display("[TB] FAIL idle_overflow got %b want 0", ovf); else passed++;
        tick();
        total++; if (bus.valid !== 1'b0) $display("[TB] FAIL idle_valid_one_cycle got %b want 0", bus.valid); else passed++;
    endtask

    task automatic test_ten_pulses();
        bit early; logic vld; logic [W-1:0] cnt; logic ovf;
        wait_to(110);
        pulses(10, 4, 4);
        run_window(early, vld, cnt, ovf);
        total++; if (early !== 1'b0) $display("[TB] FAIL ten_early_valid got %b want 0", early); else passed++;
        total++; if (vld !== 1'b1) $display("[TB] FAIL ten_valid got %b want 1", vld); else passed++;
        total++; if (cnt !== 4'd10) $display("[TB] FAIL ten_count got %0d want 10", cnt); else passed++;
        total++; if (ovf !== 1'b0) $display("[TB] FAIL ten_overflow got %b want 0", ovf); else passed++;
    endtask

    task automatic test_overflow();
        bit early; logic vld; logic [W-1:0] cnt; logic ovf;
        wait_to(205);
        pulses(20, 2, 2);
        run_window(early, vld, cnt, ovf);
        total++; if (vld !== 1'b1) $display("[TB] FAIL ovf_valid got %b want 1", vld); else passed++;
        total++; if (cnt !== OVF_CNT) $display("[TB] FAIL ovf_count got %0d want %0d", cnt, OVF_CNT); else passed++;
        total++; if (ovf !== 1'b1) $display("[TB] FAIL ovf_flag got %b want 1", ovf); else passed++;
        tick();
        total++; if (bus.count_out !== OVF_CNT) $display("[TB] FAIL ovf_count_hold got %0d want %0d", bus.count_out, OVF_CNT); else passed++;
        total++; if (bus.overflow !== 1'b1) $display("[TB] FAIL ovf_flag_hold got %b want 1", bus.overflow); else passed++;
        run_window(early, vld, cnt, ovf);
        total++; if (early !== 1'b0) $display("[TB] FAIL ovf_next_early_valid got %b want 0", early); else passed++;
        total++; if (cnt !== 4'd0) $display("[TB] FAIL ovf_next_count got %0d want 0", cnt); else passed++;
        total++; if (ovf !== 1'b0) $display("[TB] FAIL ovf_next_flag got %b want 0", ovf); else passed++;
    endtask

    // Driving high after edge 496 puts the detection exactly on the terminal cycle of the window.
    task automatic test_terminal_edge();
        bit early; logic vld; logic [W-1:0] cnt; logic ovf;
        wait_to(496);
        bus.sig_in = 1'b1;
        run_window(early, vld, cnt, ovf);
        total++; if (cnt !== 4'd1) $display("[TB] FAIL term_closing_count got %0d want 1", cnt); else passed++;
        wait_to(520);
        bus.sig_in = 1'b0;
        run_window(early, vld, cnt, ovf);
        total++; if (cnt !== 4'd0) $display("[TB] FAIL term_next_count got %0d want 0", cnt); else passed++;
    endtask

    // One cycle later than the terminal case, the detection falls into the following window.
    task automatic test_latency();
        bit early; logic vld; logic [W-1:0] cnt; logic ovf;
        wait_to(650);
        bus.sig_in = 1'b1;
        #3;
        bus.sig_in = 1'b0;
        wait_to(697);
        bus.sig_in = 1'b1;
        run_window(early, vld, cnt, ovf);
        total++; if (cnt !== 4'd0) $display("[TB] FAIL lat_closing_count got %0d want 0", cnt); else passed++;
        wait_to(720);
        bus.sig_in = 1'b0;
        run_window(early, vld, cnt, ovf);
        total++; if (cnt !== 4'd1) $display("[TB] FAIL lat_next_count got %0d want 1", cnt); else passed++;
    endtask

    task automatic test_reset_abort();
        bit early; logic vld; logic [W-1:0] cnt; logic ovf;
        bit seen;
        wait_to(810);
        pulses(5, 4, 4);
        rst = 1'b1;
        #1;
        total++; if (bus.count_out !== 4'd0) $display("[TB] FAIL abort_async_count got %0d want 0", bus.count_out); else passed++;
        seen = 1'b0;
        repeat (3) begin
            tick();
            if (bus.valid !== 1'b0) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) $display("[TB] FAIL abort_valid_in_reset got %b want 0", seen); else passed++;
        release_reset();
        wait_to(10);
        pulses(3, 4, 4);
        run_window(early, vld, cnt, ovf);
        total++; if (early !== 1'b0) $display("[TB] FAIL abort_early_valid got %b want 0", early); else passed++;
        total++; if (vld !== 1'b1) $display("[TB] FAIL abort_valid_at_100 got %b want 1", vld); else passed++;
        total++; if (cnt !== 4'd3) $display("[TB] FAIL abort_count got %0d want 3", cnt); else passed++;
        total++; if (ovf !== 1'b0) $display("[TB] FAIL abort_overflow got %b want 0", ovf); else passed++;
    endtask

    initial begin
        bus.sig_in = 1'b0;
        test_reset();
        test_idle_window();
        test_ten_pulses();
        test_overflow();
        test_terminal_edge();
        test_latency();
        test_reset_abort();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
